// File: rtl/axi_sram_bridge_mp.sv
// Multi-port SRAM-like to AXI3 bridge: round-robin arbitration, per-port outstanding
// reads tagged by port id, and a single write in flight with read-after-write hazard blocking.
module axi_sram_bridge_mp #(
  parameter int NUM_PORTS      = 2,
  parameter int RD_OUTSTANDING = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [NUM_PORTS-1:0]   sram_req,
  input  logic [NUM_PORTS-1:0]   sram_wr,
  input  logic [2*NUM_PORTS-1:0] sram_size,
  input  logic [32*NUM_PORTS-1:0] sram_addr,
  input  logic [4*NUM_PORTS-1:0] sram_wstrb,
  input  logic [32*NUM_PORTS-1:0] sram_wdata,
  output logic [NUM_PORTS-1:0]   sram_addr_ok,
  output logic [NUM_PORTS-1:0]   sram_data_ok,
  output logic [31:0]            sram_rdata,
  output logic [3:0]             arid,
  output logic [31:0]            araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [1:0]             arlock,
  output logic [3:0]             arcache,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [3:0]             rid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [3:0]             awid,
  output logic [31:0]            awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [1:0]             awlock,
  output logic [3:0]             awcache,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [3:0]             wid,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [3:0]             bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);
  localparam int NP = NUM_PORTS;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} w_state_e;
  w_state_e w_state_r, w_state_nx_s;

  logic [3:0]    rd_cnt_r [NP];
  logic [3:0]    rr_r, off_s, win_s, rr_nx_s;
  logic [4:0]    sum_s;
  logic          win_vld_s, win_rd_s, win_wr_s, w_busy_s, unused_s;
  logic [NP-1:0] rd_elig_s, wr_elig_s, addr_ok_s, rd_inc_s, rd_dec_s, rd_zero_s;
  logic [2*NP-1:0] rot_s;
  logic [31:0]   sel_addr_s, sel_wdata_s;
  logic [1:0]    sel_size_s;
  logic [3:0]    sel_wstrb_s;
  logic          arvalid_r, awvalid_r, wvalid_r;
  logic [3:0]    arid_r, awid_r, wstrb_r;
  logic [31:0]   araddr_r, awaddr_r, wdata_r;
  logic [2:0]    arsize_r, awsize_r;

  assign w_busy_s = (w_state_r != W_IDLE);
  assign unused_s = ^{rresp, bresp, rlast};

  // Per-port eligibility, counter update strobes and data_ok routing
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      rd_elig_s[p] = sram_req[p] & ~sram_wr[p] & ~arvalid_r
                   & (rd_cnt_r[p] < 4'(RD_OUTSTANDING))
                   & ~(w_busy_s & (awid_r == 4'(p)))
                   & ~(w_busy_s & (sram_addr[32*p+2 +: 30] == awaddr_r[31:2]));
      wr_elig_s[p] = sram_req[p] & sram_wr[p] & (w_state_r == W_IDLE) & (rd_cnt_r[p] == 4'd0);
      rd_dec_s[p]  = rvalid & (rid == 4'(p)) & (rd_cnt_r[p] != 4'd0);
      rd_zero_s[p] = (rd_cnt_r[p] == 4'd0);
      sram_data_ok[p] = (rvalid & (rid == 4'(p))) | (bready & bvalid & (bid == 4'(p)));
    end
  end

  // Round-robin pick: rotate eligibility so the rr pointer lands on bit 0
  always_comb begin
    rot_s     = {(rd_elig_s | wr_elig_s), (rd_elig_s | wr_elig_s)} >> rr_r;
    win_vld_s = 1'b0;
    off_s     = 4'd0;
    for (int j = NP - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        win_vld_s = 1'b1;
        off_s     = 4'(j);
      end else begin
        win_vld_s = win_vld_s;
      end
    end
    sum_s = {1'b0, rr_r} + {1'b0, off_s};
    if (sum_s >= 5'(NP)) begin
      win_s = 4'(sum_s - 5'(NP));
    end else begin
      win_s = sum_s[3:0];
    end
    if (win_s == 4'(NP - 1)) begin
      rr_nx_s = 4'd0;
    end else begin
      rr_nx_s = win_s + 4'd1;
    end
  end

  // Winner one-hot and request field mux
  always_comb begin
    sel_addr_s  = 32'd0;
    sel_wdata_s = 32'd0;
    sel_size_s  = 2'd0;
    sel_wstrb_s = 4'd0;
    for (int p = 0; p < NP; p++) begin
      addr_ok_s[p] = win_vld_s & (win_s == 4'(p));
      rd_inc_s[p]  = addr_ok_s[p] & ~sram_wr[p];
      sel_addr_s   = sel_addr_s  | ({32{addr_ok_s[p]}} & sram_addr[32*p +: 32]);
      sel_wdata_s  = sel_wdata_s | ({32{addr_ok_s[p]}} & sram_wdata[32*p +: 32]);
      sel_size_s   = sel_size_s  | ({2{addr_ok_s[p]}}  & sram_size[2*p +: 2]);
      sel_wstrb_s  = sel_wstrb_s | ({4{addr_ok_s[p]}}  & sram_wstrb[4*p +: 4]);
    end
    win_rd_s = |(addr_ok_s & ~sram_wr);
    win_wr_s = |(addr_ok_s & sram_wr);
  end

  // Round-robin pointer and per-port read counters
  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_r <= 4'd0;
      for (int p = 0; p < NP; p++) rd_cnt_r[p] <= 4'd0;
    end else begin
      if (win_vld_s) rr_r <= rr_nx_s;
      for (int p = 0; p < NP; p++) begin
        case ({rd_inc_s[p], rd_dec_s[p]})
          2'b10:   rd_cnt_r[p] <= rd_cnt_r[p] + 4'd1;
          2'b01:   rd_cnt_r[p] <= rd_cnt_r[p] - 4'd1;
          default: rd_cnt_r[p] <= rd_cnt_r[p];
        endcase
      end
    end
  end

  // AR channel register: loaded on a read accept, held until arready
  always_ff @(posedge aclk) begin
    if (areset) begin
      arvalid_r <= 1'b0;
      arid_r    <= 4'd0;
      araddr_r  <= 32'd0;
      arsize_r  <= 3'd0;
    end else if (win_rd_s) begin
      arvalid_r <= 1'b1;
      arid_r    <= win_s;
      araddr_r  <= sel_addr_s;
      arsize_r  <= {1'b0, sel_size_s};
    end else if (arready) begin
      arvalid_r <= 1'b0;
    end
  end

  // AW/W channel registers: each valid drops on its own ready
  always_ff @(posedge aclk) begin
    if (areset) begin
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      awid_r    <= 4'd0;
      awaddr_r  <= 32'd0;
      awsize_r  <= 3'd0;
      wdata_r   <= 32'd0;
      wstrb_r   <= 4'd0;
    end else if (win_wr_s) begin
      awvalid_r <= 1'b1;
      wvalid_r  <= 1'b1;
      awid_r    <= win_s;
      awaddr_r  <= sel_addr_s;
      awsize_r  <= {1'b0, sel_size_s};
      wdata_r   <= sel_wdata_s;
      wstrb_r   <= sel_wstrb_s;
    end else begin
      if (awready) awvalid_r <= 1'b0;
      if (wready)  wvalid_r  <= 1'b0;
    end
  end

  // Write FSM state register
  always_ff @(posedge aclk) begin
    if (areset) w_state_r <= W_IDLE;
    else        w_state_r <= w_state_nx_s;
  end

  // Write FSM next state
  always_comb begin
    w_state_nx_s = w_state_r;
    case (w_state_r)
      W_IDLE: if (win_wr_s) w_state_nx_s = W_SEND; else w_state_nx_s = W_IDLE;
      W_SEND: if ((~awvalid_r | awready) & (~wvalid_r | wready)) w_state_nx_s = W_RESP;
              else w_state_nx_s = W_SEND;
      W_RESP: if (bvalid) w_state_nx_s = W_IDLE; else w_state_nx_s = W_RESP;
      default: w_state_nx_s = W_IDLE;
    endcase
  end

  assign sram_addr_ok = addr_ok_s;
  assign sram_rdata   = rdata;
  assign arid    = arid_r;
  assign araddr  = araddr_r;
  assign arlen   = 8'd0;
  assign arsize  = arsize_r;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_r;
  assign rready  = 1'b1;
  assign awid    = awid_r;
  assign awaddr  = awaddr_r;
  assign awlen   = 8'd0;
  assign awsize  = awsize_r;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_r;
  assign wid     = awid_r;
  assign wdata   = wdata_r;
  assign wstrb   = wstrb_r;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_r;
  assign bready  = (w_state_r == W_RESP);

  axi_sram_bridge_mp_chk #(.NUM_PORTS(NP)) u_chk (
    .aclk      (aclk),
    .areset    (areset),
    .rvalid    (rvalid),
    .rid       (rid),
    .rd_zero   (rd_zero_s)
  );
endmodule

// Protocol checker: a read return must target a port that has reads outstanding.
module axi_sram_bridge_mp_chk #(
  parameter int NUM_PORTS = 2
) (
  input logic                 aclk,
  input logic                 areset,
  input logic                 rvalid,
  input logic [3:0]           rid,
  input logic [NUM_PORTS-1:0] rd_zero
);
  logic rid_known_s;

  // rid must name an existing port that is waiting for data
  always_comb begin
    rid_known_s = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if ((rid == 4'(p)) && !rd_zero[p]) rid_known_s = 1'b1;
      else                               rid_known_s = rid_known_s;
    end
  end

  a_rid_known: assert property (@(posedge aclk) disable iff (areset) rvalid |-> rid_known_s);
endmodule

// File: tb/tb_axi_sram_bridge_mp.sv
// Directed bench for axi_sram_bridge_mp: the bench plays both SRAM masters and the AXI slave.
module tb_axi_sram_bridge_mp;
  localparam int NP = 2;

  logic aclk = 1'b0, areset = 1'b1;
  logic [NP-1:0] sram_req, sram_wr, sram_addr_ok, sram_data_ok;
  logic [2*NP-1:0] sram_size;
  logic [32*NP-1:0] sram_addr, sram_wdata;
  logic [4*NP-1:0] sram_wstrb;
  logic [31:0] sram_rdata, araddr, rdata, awaddr, wdata;
  logic [3:0] arid, arcache, rid, awid, awcache, wid, wstrb, bid;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_chk = 0, n_fail = 0;

  axi_sram_bridge_mp #(.NUM_PORTS(NP), .RD_OUTSTANDING(4)) dut (
    .aclk(aclk), .areset(areset),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
    .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_port(input int p, input logic req, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    sram_req[p] = req;
    sram_wr[p]  = wr;
    sram_size[2*p +: 2]   = size;
    sram_addr[32*p +: 32] = addr;
    sram_wstrb[4*p +: 4]  = strb;
    sram_wdata[32*p +: 32] = data;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    sram_req = '0; sram_wr = '0; sram_size = '0; sram_addr = '0; sram_wstrb = '0; sram_wdata = '0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1;
    bvalid = 1'b0; bid = 4'd0; bresp = 2'd0;
    step();
    step();
    areset = 1'b0;
  endtask

  initial begin
    do_reset();
    areset = 1'b1;
    settle();
    check_val("rst_arvalid", 32'(arvalid), 32'd0);
    check_val("rst_awvalid", 32'(awvalid), 32'd0);
    check_val("rst_wvalid",  32'(wvalid),  32'd0);
    check_val("rst_bready",  32'(bready),  32'd0);
    check_val("rst_addr_ok", 32'(sram_addr_ok), 32'd0);
    step();
    areset = 1'b0;

    // single read on port 0
    set_port(0, 1'b1, 1'b0, 2'd2, 32'h1FC0_0000, 4'h0, 32'd0);
    settle();
    check_val("t1_addr_ok", 32'(sram_addr_ok), 32'd1);
    step();
    set_port(0, 1'b0, 1'b0, 2'd0, 32'd0, 4'h0, 32'd0);
    settle();
    check_val("t1_arvalid", 32'(arvalid), 32'd1);
    check_val("t1_arid",    32'(arid),    32'd0);
    check_val("t1_araddr",  araddr,       32'h1FC0_0000);
    check_val("t1_arsize",  32'(arsize),  32'd2);
    check_val("t1_arlen",   32'(arlen),   32'd0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_BEEF;
    settle();
    check_val("t1_arvalid_drop", 32'(arvalid), 32'd0);
    check_val("t1_data_ok", 32'(sram_data_ok), 32'd1);
    check_val("t1_rdata",   sram_rdata, 32'hDEAD_BEEF);
    step();
    rvalid = 1'b0;

    // alternating grants between two continuously reading ports
    do_reset();
    arready = 1'b1;
    set_port(0, 1'b1, 1'b0, 2'd2, 32'h0000_1000, 4'h0, 32'd0);
    set_port(1, 1'b1, 1'b0, 2'd2, 32'h0000_2000, 4'h0, 32'd0);
    for (int c = 0; c < 8; c++) begin
      settle();
      check_val($sformatf("t2_grant_c%0d", c), 32'(sram_addr_ok),
                (c % 2 == 1) ? 32'd0 : ((c % 4 == 0) ? 32'd1 : 32'd2));
      step();
    end
    sram_req = '0;
    arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rid = (k % 2 == 0) ? 4'd1 : 4'd0; rdata = 32'hA000_0000 + 32'(k);
      settle();
      check_val($sformatf("t2_data_ok_%0d", k), 32'(sram_data_ok), (k % 2 == 0) ? 32'd2 : 32'd1);
      check_val($sformatf("t2_rdata_%0d", k), sram_rdata, 32'hA000_0000 + 32'(k));
      step();
    end
    rvalid = 1'b0;

    // outstanding-read limit on port 0
    do_reset();
    arready = 1'b1;
    set_port(0, 1'b1, 1'b0, 2'd2, 32'h0000_3000, 4'h0, 32'd0);
    for (int c = 0; c < 10; c++) begin
      settle();
      check_val($sformatf("t3_grant_c%0d", c), 32'(sram_addr_ok),
                ((c % 2 == 0) && (c < 8)) ? 32'd1 : 32'd0);
      step();
    end
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_0033;
    settle();
    check_val("t3_full_ret_addr_ok", 32'(sram_addr_ok), 32'd0);
    check_val("t3_full_ret_data_ok", 32'(sram_data_ok), 32'd1);
    step();
    rvalid = 1'b0;
    settle();
    check_val("t3_after_ret_addr_ok", 32'(sram_addr_ok), 32'd1);
    step();
    sram_req = '0;

    // port 1 write with delayed awready
    do_reset();
    wready = 1'b1;
    set_port(1, 1'b1, 1'b1, 2'd1, 32'h0000_0100, 4'b0011, 32'hCAFE_1234);
    settle();
    check_val("t4_addr_ok", 32'(sram_addr_ok), 32'd2);
    step();
    sram_req = '0;
    settle();
    check_val("t4_awvalid_n1", 32'(awvalid), 32'd1);
    check_val("t4_wvalid_n1",  32'(wvalid),  32'd1);
    check_val("t4_awid",  32'(awid),  32'd1);
    check_val("t4_wid",   32'(wid),   32'd1);
    check_val("t4_awaddr", awaddr,    32'h0000_0100);
    check_val("t4_wstrb", 32'(wstrb), 32'h3);
    check_val("t4_wdata", wdata,      32'hCAFE_1234);
    check_val("t4_awsize", 32'(awsize), 32'd1);
    step();
    settle();
    check_val("t4_wvalid_n2",  32'(wvalid),  32'd0);
    check_val("t4_awvalid_n2", 32'(awvalid), 32'd1);
    step();
    settle();
    check_val("t4_awvalid_n3", 32'(awvalid), 32'd1);
    step();
    awready = 1'b1;
    settle();
    check_val("t4_awvalid_n4", 32'(awvalid), 32'd1);
    check_val("t4_bready_n4",  32'(bready),  32'd0);
    step();
    awready = 1'b0;
    settle();
    check_val("t4_awvalid_n5", 32'(awvalid), 32'd0);
    check_val("t4_bready_n5",  32'(bready),  32'd1);
    bvalid = 1'b1; bid = 4'd1;
    settle();
    check_val("t4_data_ok", 32'(sram_data_ok), 32'd2);
    step();
    bvalid = 1'b0;
    settle();
    check_val("t4_bready_done", 32'(bready), 32'd0);

    // read-after-write hazard blocking
    do_reset();
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    set_port(1, 1'b1, 1'b1, 2'd2, 32'h0000_0100, 4'hF, 32'h5555_AAAA);
    settle();
    check_val("t5_wr_addr_ok", 32'(sram_addr_ok), 32'd2);
    step();
    set_port(1, 1'b0, 1'b0, 2'd0, 32'd0, 4'h0, 32'd0);
    set_port(0, 1'b1, 1'b0, 2'd2, 32'h0000_0102, 4'h0, 32'd0);
    settle();
    check_val("t5_haz_block_a", 32'(sram_addr_ok), 32'd0);
    step();
    settle();
    check_val("t5_haz_block_b", 32'(sram_addr_ok), 32'd0);
    step();
    set_port(0, 1'b1, 1'b0, 2'd2, 32'h0000_0200, 4'h0, 32'd0);
    settle();
    check_val("t5_other_addr_ok", 32'(sram_addr_ok), 32'd1);
    step();
    set_port(0, 1'b1, 1'b0, 2'd2, 32'h0000_0102, 4'h0, 32'd0);
    settle();
    check_val("t5_haz_block_c", 32'(sram_addr_ok), 32'd0);
    step();
    bvalid = 1'b1; bid = 4'd1;
    settle();
    check_val("t5_haz_block_d", 32'(sram_addr_ok), 32'd0);
    check_val("t5_b_data_ok",   32'(sram_data_ok), 32'd2);
    step();
    bvalid = 1'b0;
    settle();
    check_val("t5_haz_release", 32'(sram_addr_ok), 32'd1);
    step();
    sram_req = '0;

    // write blocked behind own read, then reset during W_SEND
    do_reset();
    arready = 1'b1;
    set_port(0, 1'b1, 1'b0, 2'd2, 32'h0000_0300, 4'h0, 32'd0);
    settle();
    check_val("t6_rd_addr_ok", 32'(sram_addr_ok), 32'd1);
    step();
    set_port(0, 1'b1, 1'b1, 2'd2, 32'h0000_0300, 4'hF, 32'h1234_5678);
    settle();
    check_val("t6_wr_block_a", 32'(sram_addr_ok), 32'd0);
    step();
    settle();
    check_val("t6_wr_block_b", 32'(sram_addr_ok), 32'd0);
    step();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_0066;
    settle();
    check_val("t6_wr_block_ret", 32'(sram_addr_ok), 32'd0);
    check_val("t6_r_data_ok",    32'(sram_data_ok), 32'd1);
    step();
    rvalid = 1'b0;
    settle();
    check_val("t6_wr_accept", 32'(sram_addr_ok), 32'd1);
    step();
    sram_req = '0;
    settle();
    check_val("t6_awvalid_send", 32'(awvalid), 32'd1);
    check_val("t6_wvalid_send",  32'(wvalid),  32'd1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    settle();
    check_val("t6_rst_awvalid", 32'(awvalid), 32'd0);
    check_val("t6_rst_wvalid",  32'(wvalid),  32'd0);
    check_val("t6_rst_arvalid", 32'(arvalid), 32'd0);
    check_val("t6_rst_bready",  32'(bready),  32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
